// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state encoding for the mux channel arbiter
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mux_channel_arbiter_rr_pick4.sv
// rtl/mux_channel_arbiter_rr_pick4.sv - priority-from-pointer pick among 4 requesters
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  // Scan farthest offset first so the closest set request to ptr wins.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx   = ptr + SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_channel_arbiter.sv
// rtl/mux_channel_arbiter.sv - round-robin owner scheduler for a shared 4:1 mux / 1:4 demux channel
module mux_channel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST  = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy
);

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic               r_sel_valid;
  logic               r_busy;
  logic [7:0]         r_burst_cnt;
  logic [3:0]         r_gap_cnt;
  logic [SEL_W-1:0]   r_ptr;

  logic [SEL_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic               w_release;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  assign w_pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
  // r_sel doubles as the owner index while a grant is active.
  assign w_release     = !req[r_sel] || (r_burst_cnt == BURST_LIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
      r_ptr       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && w_pick_found) begin
            r_state     <= GRANT;
            r_gnt       <= w_pick_onehot;
            r_sel       <= w_pick_idx;
            r_sel_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_burst_cnt <= 8'd1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_gnt       <= '0;
            r_sel_valid <= 1'b0;
            r_ptr       <= r_sel + SEL_W'(1);
            r_burst_cnt <= '0;
            if (GAP_LOAD != 4'd0) begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
            end
          end else begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
        GAP: begin
          if (r_gap_cnt <= 4'd1) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mux_channel_arbiter.sv
// tb/tb_mux_channel_arbiter.sv - directed vector and sequence bench for mux_channel_arbiter
module tb_mux_channel_arbiter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       sel_valid;
  logic       busy;
  logic [3:0] gnt1;
  logic [1:0] sel1;
  logic       sel_valid1;
  logic       busy1;

  int checks   = 0;
  int failures = 0;

  mux_channel_arbiter #(.MAX_BURST(8), .GAP_CYCLES(1)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy)
  );

  mux_channel_arbiter #(.MAX_BURST(1), .GAP_CYCLES(0)) u_dut_min (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt1),
    .sel       (sel1),
    .sel_valid (sel_valid1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sv;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [3:0] rq,
                     input logic [3:0] g, input logic [1:0] s, input logic v, input logic b);
    vec_t x;
    x.rst_n = r; x.en = e; x.req = rq; x.gnt = g; x.sel = s; x.sv = v; x.busy = b;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b1; req = 4'b0000;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic wait_start(input int idx);
    int n;
    n = 0;
    while (!sel_valid && n < 20) begin
      tick();
      n++;
    end
    chk("grant_start", {31'd0, sel_valid}, 32'd1);
    chk("grant_onehot", {28'd0, gnt}, 32'd1 << idx);
    chk("grant_sel", {30'd0, sel}, idx);
  endtask

  task automatic measure(input int idx, input int exp_len);
    int len;
    len = 0;
    while (sel_valid && len < 300) begin
      len++;
      tick();
    end
    chk("grant_len", len, exp_len);
    chk("sel_hold", {30'd0, sel}, idx);
    chk("gap_busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; req = 4'b0000;

    // Reset held with all requests, then single requester 2 via burst, gap, idle, re-grant.
    for (int i = 0; i < 3; i++) add(0, 1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(1, 1, 4'b1111, 4'b0001, 2'd0, 1, 1);
    add(1, 1, 4'b0000, 4'b0000, 2'd0, 0, 1);
    add(1, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(1, 1, 4'b0100, 4'b0000, 2'd2, 0, 1);
    add(1, 1, 4'b0100, 4'b0000, 2'd2, 0, 0);
    add(1, 1, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(1, 1, 4'b0000, 4'b0000, 2'd2, 0, 1);
    add(1, 1, 4'b0000, 4'b0000, 2'd2, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst_n; enable = vecs[i].en; req = vecs[i].req;
      tick();
      chk($sformatf("vec%0d_gnt", i), {28'd0, gnt}, {28'd0, vecs[i].gnt});
      chk($sformatf("vec%0d_sel", i), {30'd0, sel}, {30'd0, vecs[i].sel});
      chk($sformatf("vec%0d_sv", i), {31'd0, sel_valid}, {31'd0, vecs[i].sv});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
    end

    // Round robin with every requester asserted.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start(g % 4);
      measure(g % 4, 8);
    end

    // Early drop of requester 1 in its third grant cycle, then wrap to 0.
    do_reset();
    req = 4'b0010;
    wait_start(1);
    tick(); tick();
    req = 4'b0000;
    tick();
    chk("drop_gnt", {28'd0, gnt}, 32'd0);
    chk("drop_busy", {31'd0, busy}, 32'd1);
    req = 4'b0011;
    tick();
    chk("drop_gap_no_arb", {28'd0, gnt}, 32'd0);
    chk("drop_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("drop_wrap_gnt", {28'd0, gnt}, 32'b0001);

    // Enable low during a grant to requester 3: burst completes, then stays idle.
    do_reset();
    req = 4'b1000;
    wait_start(3);
    enable = 1'b0; req = 4'b1111;
    measure(3, 8);
    for (int i = 0; i < 4; i++) tick();
    chk("en_idle_gnt", {28'd0, gnt}, 32'd0);
    chk("en_idle_busy", {31'd0, busy}, 32'd0);
    chk("en_idle_sel", {30'd0, sel}, 32'd3);
    enable = 1'b1;
    tick();
    chk("en_resume_gnt", {28'd0, gnt}, 32'b0001);

    // Reset in the fourth cycle of a grant to requester 2.
    do_reset();
    req = 4'b0100;
    wait_start(2);
    tick(); tick(); tick();
    chk("mid_pre_gnt", {28'd0, gnt}, 32'b0100);
    reset = 1'b0;
    tick();
    chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_sel", {30'd0, sel}, 32'd0);
    chk("mid_rst_sv", {31'd0, sel_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1; req = 4'b1111;
    tick();
    chk("mid_ptr_reset", {28'd0, gnt}, 32'b0001);

    // MAX_BURST=1, GAP_CYCLES=0 instance: one-cycle grants separated by one idle cycle.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("min_gnt%0d", k), {28'd0, gnt1}, (k % 2 == 0) ? (32'd1 << (k / 2)) : 32'd0);
      chk($sformatf("min_busy%0d", k), {31'd0, busy1}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_channel_arbiter.md
Name: mux_channel_arbiter

Overview:
- Round-robin scheduler that time-shares one 4:1 mux / 1:4 demux bit channel among 4 requesters.
- Grants one requester at a time and drives the 2-bit select shared by the mux and demux.
- Bounds each grant to a maximum burst length, then inserts a programmable idle gap before re-arbitrating.
- Sits between requester logic and the mux/demux pair.

Parameters:
- MAX_BURST, 8, maximum consecutive grant cycles per owner; legal range 1..255.
- GAP_CYCLES, 1, idle cycles after each grant before the next arbitration; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- enable  input  1  1 = new grants allowed; 0 = no new grants, and the current grant runs to completion.
- req  input  4  per-requester request, level-sensitive.
- gnt  output  4  one-hot grant; all-zero when no owner.
- sel  output  2  select to the mux S and demux S; the index of the current/last owner.
- sel_valid  output  1  1 while a grant is active; downstream gates demux output with this.
- busy  output  1  1 in GRANT or GAP state.

Behaviour:
- Reset (reset==0 at a clk edge): gnt=0, sel=0, sel_valid=0, busy=0, state=IDLE, burst count=0, rr pointer=0. Applies mid-burst; the grant is dropped at that same edge.
- All outputs are registered. There are no combinational paths from req to gnt.
- States:
  - IDLE: if enable && |req, pick the first set req[i] scanning from the rr pointer upward with wrap (pointer, pointer+1, ... mod 4). Next edge: state=GRANT, gnt=1<<i, sel=i, sel_valid=1, busy=1, count=1. Latency: req rises at edge t, gnt visible after edge t+1.
  - GRANT: each cycle, sample req[owner] and count.
    - If req[owner]==0 or count==MAX_BURST, release at the next edge: gnt=0, sel_valid=0, rr pointer=(owner+1) mod 4. Then state=GAP with gap count=GAP_CYCLES if GAP_CYCLES>0, else state=IDLE (busy=0).
    - Otherwise count increments.
    - A grant lasts exactly MAX_BURST cycles when req is held.
  - GAP: gap count decrements each cycle. When it reaches 0, state=IDLE and busy=0. Arbitration never happens in GAP.
- sel holds its last value when sel_valid=0; it changes only on a new grant. This keeps the mux input stable.
- Requests from non-owners during GRANT/GAP are ignored; they are not latched and must stay asserted to be considered.
- Owner drop and burst limit in the same cycle: a single release, identical to either alone.
- enable=0 during GRANT: no effect on the current grant. enable=0 in IDLE: stay IDLE, outputs unchanged.
- The rr pointer advances only on release. A requester that keeps asserting cannot starve the others.
- Width rules: burst counter is 8 bits and gap counter 4 bits. Comparisons are unsigned. Pointer arithmetic is mod 4 by 2-bit wrap.
- MAX_BURST=1: every grant lasts one cycle. GAP_CYCLES=0: the minimum spacing between grants is one IDLE cycle.

Decomposition:
- Shared package mux_arb_pkg: state enum (IDLE, GRANT, GAP), NUM_REQ=4 constant, SEL_W=2 constant.
- One natural sub-module: rr_pick4, a combinational priority-from-pointer encoder (inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and found).
- The FSM and counters stay in mux_channel_arbiter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 -> gnt=0, sel=0, sel_valid=0, busy=0 throughout. Release reset -> gnt=4'b0001 one cycle after the first enabled edge.
- Single requester: req=4'b0100 held, MAX_BURST=8, GAP_CYCLES=1 -> gnt=4'b0100 and sel=2 for exactly 8 cycles, then 1 GAP cycle + 1 IDLE cycle, then re-grant to requester 2.
- Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0, each grant 8 cycles long. sel tracks the owner and holds its value during gaps.
- Early drop: requester 1 granted, req[1] drops in the 3rd grant cycle -> gnt=0 on the next edge, and the pointer becomes 2. If req=4'b0011 afterwards, the next grant goes to 0 (wrap) after the gap.
- Enable gating: enable=0 while requester 3 is granted -> the burst completes to 8 cycles. The arbiter then stays IDLE with req=4'b1111 until enable=1, and the next grant goes to 0.
- Reset mid-burst: reset=0 in the 4th cycle of a grant to requester 2 -> at that edge gnt=0, sel=0, sel_valid=0, and the pointer resets to 0.
